tcm_trigger_rx: RTL and testbench

- TCM-side receiver for the per-channel trigger lanes (tt, ta) driven by trigger_wrapper on the PM.
- Issues the tcm_req request pulse, aligned to the 320 MHz bunch-phase counter mt_cou.
- Deserialises the 2-bit-wide tt/ta response over the 8 phases of the following bunch, then checks marker and parity.
- Presents decoded 14-bit time/amplitude trigger words with a valid pulse to the TCM trigger logic.

---
 rtl/tcm_trigger_rx_if.sv | 32 +++
 rtl/tcm_trigger_rx.sv | 132 +++++++++++++
 tb/tb_tcm_trigger_rx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tcm_trigger_rx_if.sv
// Trigger-lane bundle between the TCM trigger logic, the PM lanes and tcm_trigger_rx.
// The slave modport is the receiver. The master modport is the side that drives it.
interface tcm_trigger_rx_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [2:0]       mt_cou;
  logic [1:0]       tt;
  logic [1:0]       ta;
  logic             tcm_req;
  logic [13:0]      trig_t;
  logic [13:0]      trig_a;
  logic             trig_valid;
  logic             par_err;
  logic             miss_err;
  logic             phase_err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] frame_cnt;

  modport slave (
    input  en, mt_cou, tt, ta,
    output tcm_req, trig_t, trig_a, trig_valid, par_err, miss_err, phase_err,
           err_cnt, miss_cnt, frame_cnt
  );

  modport master (
    output en, mt_cou, tt, ta,
    input  tcm_req, trig_t, trig_a, trig_valid, par_err, miss_err, phase_err,
           err_cnt, miss_cnt, frame_cnt
  );
endinterface

// File: rtl/tcm_trigger_rx.sv
// TCM receiver for the PM tt/ta trigger lanes: requests one frame per bunch, deserialises it, checks it and decodes it.
// Optional saturating statistics counters are enabled with the macro TCM_TRIG_RX_STATS_EN.
module tcm_trigger_rx #(
  parameter int CNT_W = 16
) (
  input  logic                clk320,
  input  logic                rst,
  tcm_trigger_rx_if.slave     bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state, state_n;
  logic [2:0]  mt_q;
  logic [13:0] sh_t, sh_a, sh_t_n, sh_a_n;
  logic [15:0] word_t, word_a;
  logic        req_n, valid_n, par_n, miss_n, phase_n;
  logic        tcm_req, trig_valid, par_err, miss_err, phase_err;
  logic [13:0] trig_t, trig_a;

  // The current lane pair completes the word when it is the phase-7 sample.
  assign word_t = {sh_t, bus.tt};
  assign word_a = {sh_a, bus.ta};

  always_ff @(posedge clk320 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    sh_t_n  = sh_t;
    sh_a_n  = sh_a;
    req_n   = 1'b0;
    valid_n = 1'b0;
    par_n   = 1'b0;
    miss_n  = 1'b0;
    phase_n = 1'b0;
    case (state)
      IDLE: begin
        sh_t_n = '0;
        sh_a_n = '0;
        if (bus.en && bus.mt_cou == 3'd7) begin
          req_n   = 1'b1;
          state_n = RECV;
        end
      end
      RECV: begin
        // mt_q is 7 on the first receive cycle, so this also demands phase 0 there.
        if (bus.mt_cou != mt_q + 3'd1) begin
          phase_n = 1'b1;
          sh_t_n  = '0;
          sh_a_n  = '0;
          state_n = IDLE;
        end else begin
          sh_t_n = word_t[13:0];
          sh_a_n = word_a[13:0];
          if (bus.mt_cou == 3'd7) begin
            if (!word_t[15] || !word_a[15])   miss_n  = 1'b1;
            else if ((^word_t) || (^word_a))  par_n   = 1'b1;
            else                              valid_n = 1'b1;
            req_n   = bus.en;
            state_n = bus.en ? RECV : IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk320 or posedge rst) begin
    if (rst) begin
      mt_q       <= 3'd0;
      sh_t       <= '0;
      sh_a       <= '0;
      tcm_req    <= 1'b0;
      trig_valid <= 1'b0;
      par_err    <= 1'b0;
      miss_err   <= 1'b0;
      phase_err  <= 1'b0;
      trig_t     <= '0;
      trig_a     <= '0;
    end else begin
      mt_q       <= bus.mt_cou;
      sh_t       <= sh_t_n;
      sh_a       <= sh_a_n;
      tcm_req    <= req_n;
      trig_valid <= valid_n;
      par_err    <= par_n;
      miss_err   <= miss_n;
      phase_err  <= phase_n;
      if (valid_n) begin
        trig_t <= word_t[14:1];
        trig_a <= word_a[14:1];
      end
    end
  end

  assign bus.tcm_req    = tcm_req;
  assign bus.trig_valid = trig_valid;
  assign bus.par_err    = par_err;
  assign bus.miss_err   = miss_err;
  assign bus.phase_err  = phase_err;
  assign bus.trig_t     = trig_t;
  assign bus.trig_a     = trig_a;

`ifdef TCM_TRIG_RX_STATS_EN
  logic [CNT_W-1:0] err_q, miss_q, frame_q;

  // Counters step on the same edge that raises their pulse and stick at all-ones.
  always_ff @(posedge clk320 or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      miss_q  <= '0;
      frame_q <= '0;
    end else begin
      if (par_n && err_q != {CNT_W{1'b1}})     err_q   <= err_q + 1'b1;
      if (miss_n && miss_q != {CNT_W{1'b1}})   miss_q  <= miss_q + 1'b1;
      if (valid_n && frame_q != {CNT_W{1'b1}}) frame_q <= frame_q + 1'b1;
    end
  end

  assign bus.err_cnt   = err_q;
  assign bus.miss_cnt  = miss_q;
  assign bus.frame_cnt = frame_q;
`else
  assign bus.err_cnt   = '0;
  assign bus.miss_cnt  = '0;
  assign bus.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_tcm_trigger_rx.sv
// Bench for tcm_trigger_rx: directed and random frames are compared cycle by cycle with a frame-level reference model.
// The expected counter values follow TCM_TRIG_RX_STATS_EN.
module tb_tcm_trigger_rx;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk320 = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   ph;
  int   vcount;

  always #5 clk320 = ~clk320;

  tcm_trigger_rx_if #(.CNT_W(CNT_W)) bus ();
  tcm_trigger_rx #(.CNT_W(CNT_W)) dut (.clk320(clk320), .rst(rst), .bus(bus));

  // Reference model: collected bit pairs plus the expected registered outputs.
  bit m_recv;
  int m_prev, m_n, m_wt, m_wa;
  bit e_req, e_valid, e_par, e_miss, e_phase;
  int e_t, e_a, e_err, e_mis, e_frm;

  function automatic int cnt_view(input int v);
`ifdef TCM_TRIG_RX_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  function automatic logic [15:0] make_word(input int payload, input int kind);
    int w;
    w = 32'h8000 | ((payload & 32'h3FFF) << 1);
    if (kind == 2) w = w & 32'h7FFF;
    if ($countones(w) % 2 == 1) w = w | 1;
    if (kind == 1) w = w ^ 1;
    return w[15:0];
  endfunction

  task automatic model_reset();
    m_recv = 0; m_prev = 0; m_n = 0; m_wt = 0; m_wa = 0;
    e_req = 0; e_valid = 0; e_par = 0; e_miss = 0; e_phase = 0;
    e_t = 0; e_a = 0; e_err = 0; e_mis = 0; e_frm = 0;
  endtask

  task automatic model_step(input int m, input bit e, input int t, input int a);
    e_req = 0; e_valid = 0; e_par = 0; e_miss = 0; e_phase = 0;
    if (!m_recv) begin
      if (e && m == 7) begin
        e_req = 1; m_recv = 1; m_n = 0; m_wt = 0; m_wa = 0;
      end
    end else if (m != (m_prev + 1) % 8) begin
      e_phase = 1; m_recv = 0;
    end else begin
      m_wt = (m_wt << 2) | t;
      m_wa = (m_wa << 2) | a;
      m_n++;
      if (m_n == 8) begin
        if (((m_wt >> 15) & 1) == 0 || ((m_wa >> 15) & 1) == 0) begin
          e_miss = 1; e_mis = sat_inc(e_mis);
        end else if ($countones(m_wt) % 2 == 1 || $countones(m_wa) % 2 == 1) begin
          e_par = 1; e_err = sat_inc(e_err);
        end else begin
          e_valid = 1; e_frm = sat_inc(e_frm);
          e_t = (m_wt >> 1) & 32'h3FFF;
          e_a = (m_wa >> 1) & 32'h3FFF;
        end
        m_recv = e; e_req = e; m_n = 0; m_wt = 0; m_wa = 0;
      end
    end
    m_prev = m;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check_output("tcm_req",    32'(bus.tcm_req),    32'(e_req));
    check_output("trig_valid", 32'(bus.trig_valid), 32'(e_valid));
    check_output("par_err",    32'(bus.par_err),    32'(e_par));
    check_output("miss_err",   32'(bus.miss_err),   32'(e_miss));
    check_output("phase_err",  32'(bus.phase_err),  32'(e_phase));
    check_output("trig_t",     32'(bus.trig_t),     e_t);
    check_output("trig_a",     32'(bus.trig_a),     e_a);
    check_output("err_cnt",    32'(bus.err_cnt),    cnt_view(e_err));
    check_output("miss_cnt",   32'(bus.miss_cnt),   cnt_view(e_mis));
    check_output("frame_cnt",  32'(bus.frame_cnt),  cnt_view(e_frm));
  endtask

  // One clk320 cycle at the bench phase ph; inputs change on the falling edge.
  task automatic apply_stimulus(input bit e, input int t, input int a);
    @(negedge clk320);
    bus.mt_cou = ph[2:0];
    bus.en     = e;
    bus.tt     = t[1:0];
    bus.ta     = a[1:0];
    @(posedge clk320);
    model_step(ph, e, t, a);
    if (bus.trig_valid === 1'b1) vcount++;
    #1 check_all();
    ph = (ph + 1) % 8;
  endtask

  task automatic send_bunch(input logic [15:0] wt, input logic [15:0] wa, input bit e);
    for (int k = 0; k < 8; k++)
      apply_stimulus(e, (wt >> (14 - 2 * k)) & 3, (wa >> (14 - 2 * k)) & 3);
  endtask

  task automatic lead_in(input bit e);
    int last;
    do begin
      last = ph;
      apply_stimulus(e, 0, 0);
    end while (last != 7);
  endtask

  initial begin
    logic [15:0] wt, wa;
    int kind;
    rst = 1'b1;
    bus.en = 1'b0; bus.mt_cou = 3'd0; bus.tt = 2'd0; bus.ta = 2'd0;
    ph = 0; vcount = 0;
    model_reset();
    repeat (3) @(posedge clk320);
    @(negedge clk320);
    check_all();
    rst = 1'b0;

    // Good frame, then parity error, then missing marker.
    lead_in(1'b1);
    send_bunch(16'h8002, 16'hD554, 1'b1);
    check_output("good_t", 32'(bus.trig_t), 32'h0001);
    check_output("good_a", 32'(bus.trig_a), 32'h2AAA);
    send_bunch(16'h8003, 16'hD554, 1'b1);
    check_output("par_hold_t", 32'(bus.trig_t), 32'h0001);
    send_bunch(16'h0002, 16'hD554, 1'b1);
    check_output("miss_par", 32'(bus.par_err), 32'h0);

    // Four streamed frames, with en dropped during the last one.
    vcount = 0;
    for (int i = 0; i < 4; i++)
      send_bunch(make_word($urandom, 0), make_word($urandom, 0), i < 3);
    send_bunch(16'h8002, 16'h8002, 1'b0);
    check_output("stream_valids", vcount, 4);

    // Phase glitch 3 -> 5, then recovery at the next phase 7.
    lead_in(1'b1);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 2, 2);
    ph = 5;
    apply_stimulus(1'b1, 0, 0);
    apply_stimulus(1'b1, 0, 0);
    apply_stimulus(1'b1, 0, 0);
    send_bunch(16'h8002, 16'hD554, 1'b1);
    check_output("glitch_recover_t", 32'(bus.trig_t), 32'h0001);

    // Random frames with random faults and random enable.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
      wt = make_word($urandom, kind);
      wa = make_word($urandom, $urandom_range(0, 5) == 0 ? 1 : 0);
      send_bunch(wt, wa, $urandom_range(0, 4) != 0);
    end

    // Counter saturation.
    lead_in(1'b1);
    for (int i = 0; i < 17; i++)
      send_bunch(make_word($urandom, 1), make_word($urandom, 0), 1'b1);
    check_output("err_sat", 32'(bus.err_cnt), cnt_view(SAT));

    // Reset in the middle of a frame.
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 2, 1);
    @(negedge clk320);
    rst = 1'b1;
    model_reset();
    #1 check_all();
    check_output("rst_trig_t", 32'(bus.trig_t), 32'h0);
    check_output("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
    repeat (2) @(posedge clk320);
    @(negedge clk320);
    rst = 1'b0;
    ph = 0;
    lead_in(1'b1);
    send_bunch(16'h8002, 16'hD554, 1'b0);
    check_output("post_rst_a", 32'(bus.trig_a), 32'h2AAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
